dm_access_ctrl: RTL and testbench

Sequences CPU data-memory loads and stores onto a req/ack memory bus that may insert wait states. It sits between the MEM stage and the data-memory/bridge port. It derives byte enables and lane-aligned write data, and extracts and extends load data. It stalls the pipeline until the access completes, and reports misaligned-address exceptions and bus timeouts.

---
 rtl/dm_access_ctrl_if.sv | 27 ++
 rtl/dm_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl_if
// Purpose  : Data-memory request/acknowledge bus between the access
//            controller (master) and the memory or bridge port (slave).
// Revision : 1.0  initial release
// ============================================================================
interface dm_access_ctrl_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata,
    output m_ack, m_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Sequences MEM-stage loads/stores onto a req/ack memory bus with
//            wait states: lane steering, load extension, pipeline stall,
//            misalignment exceptions and bus timeout.
// Revision : 1.0  initial release
// ============================================================================
module dm_access_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        req,
  input  wire logic        we,
  input  wire logic [1:0]  size,
  input  wire logic        signed_ld,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             done,
  output logic             adel,
  output logic             ades,
  output logic             bus_timeout,
  dm_access_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_EXC  = 2'd3;

  // Last wait-count value before the access is abandoned
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;

  logic        misaligned;
  logic        wait_expired;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode: alignment, lane enables and replicated store data
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = wdata;
    unique case (size)
      2'b00: begin
        misaligned = 1'b0;
        be_new     = 4'b0001 << addr[1:0];
        wdata_new  = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_new     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = |addr[1:0];
        be_new     = 4'b1111;
        wdata_new  = wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an ack always wins over an expiring wait counter
  always_comb begin
    state_next   = state;
    wait_expired = (wait_cnt == WAIT_LAST);
    unique case (state)
      ST_IDLE: if (req) state_next = misaligned ? ST_EXC : ST_BUSY;
      ST_BUSY: if (bus.m_ack || wait_expired) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      ST_EXC:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: stall and extension of the returned load word
  always_comb begin
    stall   = ((state == ST_IDLE) && req) || (state == ST_BUSY);
    ld_byte = bus.m_rdata[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    unique case (lat_size)
      2'b00:   ld_ext = {{24{lat_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{lat_signed & ld_half[15]}}, ld_half};
      default: ld_ext = bus.m_rdata;
    endcase
  end

  // Registered bus outputs, result capture, wait counter and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= 32'd0;
      bus.m_be    <= 4'd0;
      bus.m_wdata <= 32'd0;
      rdata       <= 32'd0;
      done        <= 1'b0;
      adel        <= 1'b0;
      ades        <= 1'b0;
      bus_timeout <= 1'b0;
      wait_cnt    <= 8'd0;
      lat_size    <= 2'd0;
      lat_signed  <= 1'b0;
      lat_off     <= 2'd0;
    end else begin
      done        <= 1'b0;
      adel        <= 1'b0;
      ades        <= 1'b0;
      bus_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req && misaligned) begin
            adel <= ~we;
            ades <= we;
          end else if (req) begin
            lat_size    <= size;
            lat_signed  <= signed_ld;
            lat_off     <= addr[1:0];
            bus.m_addr  <= {addr[31:2], 2'b00};
            bus.m_we    <= we;
            bus.m_be    <= be_new;
            bus.m_wdata <= wdata_new;
            bus.m_req   <= 1'b1;
            wait_cnt    <= 8'd0;
          end
        end
        ST_BUSY: begin
          if (bus.m_ack) begin
            rdata     <= ld_ext;
            bus.m_req <= 1'b0;
            done      <= 1'b1;
          end else if (wait_expired) begin
            rdata       <= 32'd0;
            bus.m_req   <= 1'b0;
            done        <= 1'b1;
            bus_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_ctrl
// Purpose  : Scoreboard bench for dm_access_ctrl with a behavioural model,
//            a wait-state memory responder and an output monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_access_ctrl;
  localparam int MW = 4;

  typedef struct {
    int          kind;     // 0 completion, 1 load exception, 2 store exception
    logic [31:0] rdata;
    logic        to;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall_n;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        adel;
  logic        ades;
  logic        bus_timeout;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .done(done), .adel(adel), .ades(ades),
    .bus_timeout(bus_timeout), .bus(bus)
  );

  int          n_checks;
  int          n_pass;
  exp_t        sbq[$];
  int          ack_delay;
  logic [31:0] resp_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Reference: access width in bytes drives alignment, lanes and extension
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int dly, input logic [31:0] mw);
    exp_t e;
    int n;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    e.kind = 0; e.rdata = '0; e.to = 1'b0; e.we = w;
    e.addr = {a[31:2], 2'b00}; e.be = '0; e.wdata = '0; e.stall_n = 1;
    if (off % n != 0) begin
      e.kind = w ? 2 : 1;
      return e;
    end
    e.be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    v    = mw >> (8 * off);
    mask = 32'((64'd1 << (8 * n)) - 64'd1);
    v    = v & mask;
    if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
    if (dly >= MW) begin
      e.to = 1'b1; e.rdata = 32'd0; e.stall_n = 1 + MW;
    end else begin
      e.rdata = v; e.stall_n = dly + 2;
    end
    return e;
  endfunction

  // Memory responder: ack after ack_delay wait cycles, random stray acks when idle
  initial begin
    int busy_n;
    busy_n = 0;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req) begin
        if (busy_n == ack_delay) begin
          bus.m_ack = 1'b1; bus.m_rdata = resp_data;
        end else begin
          bus.m_ack = 1'b0; bus.m_rdata = $urandom;
        end
        busy_n++;
      end else begin
        busy_n = 0;
        bus.m_ack = 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
      end
    end
  end

  // Monitor: count stall cycles and check every completion/exception pulse
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk); #1;
      if (reset) stall_cnt = 0;
      else begin
        if (stall) stall_cnt++;
        if (done || adel || ades) begin
          if (sbq.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall_n));
            chk("m_req_low", {31'd0, bus.m_req}, 32'd0);
            if (e.kind == 0) begin
              chk("done", {29'd0, done, adel, ades}, 32'h4);
              chk("bus_timeout", {31'd0, bus_timeout}, {31'd0, e.to});
              chk("rdata", rdata, e.rdata);
              chk("m_we", {31'd0, bus.m_we}, {31'd0, e.we});
              chk("m_addr", bus.m_addr, e.addr);
              chk("m_be", {28'd0, bus.m_be}, {28'd0, e.be});
              chk("m_wdata", bus.m_wdata, e.wdata);
            end else begin
              chk("exception", {29'd0, done, adel, ades}, (e.kind == 1) ? 32'h2 : 32'h1);
              chk("exc_timeout", {31'd0, bus_timeout}, 32'd0);
            end
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Issue one access at a negedge and hold req until the DUT reports an outcome
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] mw);
    bit seen;
    sbq.push_back(model(w, sz, sg, a, wd, dly, mw));
    ack_delay = dly; resp_data = mw;
    req = 1'b1; we = w; size = sz; signed_ld = sg; addr = a; wdata = wd;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done || adel || ades) seen = 1'b1;
    end
    if (!seen) chk("op_completion_wait", 32'd0, 32'd1);
    req = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    n_checks = 0; n_pass = 0;
    ack_delay = 0; resp_data = '0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; signed_ld = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pulses", {28'd0, done, adel, ades, bus_timeout}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_m_bus", {27'd0, bus.m_we, bus.m_be}, 32'd0);
    chk("rst_m_addr", bus.m_addr | bus.m_wdata, 32'd0);

    do_op(1, 2'b10, 0, 32'h0000_1000, 32'hDEAD_BEEF, 0, $urandom);
    do_op(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 3, $urandom);
    do_op(0, 2'b00, 1, 32'h0000_2002, $urandom, 1, 32'h12F0_3456);
    do_op(0, 2'b01, 0, 32'h0000_2002, $urandom, 0, 32'h12F0_3456);
    do_op(0, 2'b10, 0, 32'h0000_2000, $urandom, 2, 32'h12F0_3456);
    do_op(0, 2'b10, 0, 32'h0000_3001, $urandom, 0, $urandom);
    do_op(1, 2'b01, 0, 32'h0000_3001, $urandom, 0, $urandom);
    do_op(1, 2'b00, 0, 32'h0000_3001, 32'h1234_5677, 0, $urandom);
    do_op(0, 2'b10, 0, 32'h0000_4000, $urandom, 100, 32'hCAFE_F00D);
    do_op(0, 2'b01, 1, 32'h0000_4006, $urandom, MW - 1, 32'h8001_7FFF);

    // Reset during the second BUSY cycle, with an ack landing in that cycle
    ack_delay = 1; resp_data = 32'h5555_AAAA;
    req = 1'b1; we = 1'b0; size = 2'b10; signed_ld = 1'b0; addr = 32'h0000_5000;
    repeat (2) @(negedge clk);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_busy_done", {30'd0, done, bus_timeout}, 32'd0);
    repeat (2) @(negedge clk);
    do_op(1, 2'b01, 0, 32'h0000_0000, 32'h0000_BEEF, 1, $urandom);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, $urandom_range(0, MW + 1), $urandom);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
